v_div: RTL and testbench

- Packed-SIMD integer divide/remainder unit for the vector coprocessor; the inverse-operation companion of the packed multiplier.
- Takes one 32-bit element word split into 4×8, 2×16 or 1×32 lanes per `sew`.
- Runs iterative restoring division, one quotient bit per lane per cycle.
- Returns quotient or remainder through a valid/ready handshake.
- Sits in the vector execute stage beside the multiplier.

---
 rtl/v_div_pkg.sv | 95 +++++++++
 rtl/v_div_step.sv | 56 +++++
 rtl/v_div.sv | 142 ++++++++++++++
 tb/tb_v_div.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/v_div_pkg.sv
// Shared encodings and lane helpers for the packed-SIMD divider.
// Lane helpers view the 32-bit word as 4 bytes grouped into lanes by sew.
package v_div_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] SEW_8  = 3'b000;
    localparam logic [2:0] SEW_16 = 3'b001;
    localparam logic [2:0] SEW_32 = 3'b010;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    // Element width in bits, which is also the number of CALC iterations.
    function automatic logic [5:0] n_iter(input logic [2:0] sew);
        case (sew)
            SEW_8:   n_iter = 6'd8;
            SEW_16:  n_iter = 6'd16;
            SEW_32:  n_iter = 6'd32;
            default: n_iter = 6'd0;
        endcase
    endfunction

    function automatic logic sew_legal(input logic [2:0] sew);
        sew_legal = (sew == SEW_8) || (sew == SEW_16) || (sew == SEW_32);
    endfunction

    // Bytes that begin a lane; a borrow never propagates into these.
    function automatic logic [3:0] lane_start(input logic [2:0] sew);
        case (sew)
            SEW_8:   lane_start = 4'b1111;
            SEW_16:  lane_start = 4'b0101;
            default: lane_start = 4'b0001;
        endcase
    endfunction

    function automatic logic [3:0] lane_top(input logic [2:0] sew);
        case (sew)
            SEW_8:   lane_top = 4'b1111;
            SEW_16:  lane_top = 4'b1010;
            default: lane_top = 4'b1000;
        endcase
    endfunction

    function automatic logic [1:0] lane_of_byte(input logic [2:0] sew, input logic [1:0] b);
        case (sew)
            SEW_8:   lane_of_byte = b;
            SEW_16:  lane_of_byte = {1'b0, b[1]};
            default: lane_of_byte = 2'd0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] msb_mask(input logic [2:0] sew);
        case (sew)
            SEW_8:   msb_mask = 32'h8080_8080;
            SEW_16:  msb_mask = 32'h8000_8000;
            default: msb_mask = 32'h8000_0000;
        endcase
    endfunction

    // Per-lane MSB, indexed by lane number; unused lanes read as 0.
    function automatic logic [3:0] lane_msb(input logic [XLEN-1:0] x, input logic [2:0] sew);
        case (sew)
            SEW_8:   lane_msb = {x[31], x[23], x[15], x[7]};
            SEW_16:  lane_msb = {2'b00, x[31], x[15]};
            default: lane_msb = {3'b000, x[31]};
        endcase
    endfunction

    function automatic logic [3:0] lane_zero(input logic [XLEN-1:0] x, input logic [2:0] sew);
        logic [3:0] z;
        for (int b = 0; b < 4; b++) z[b] = (x[8*b +: 8] == 8'h00);
        case (sew)
            SEW_8:   lane_zero = z;
            SEW_16:  lane_zero = {2'b00, &z[3:2], &z[1:0]};
            default: lane_zero = {3'b000, &z};
        endcase
    endfunction

    // Two's-complement negate the lanes flagged in neg.
    function automatic logic [XLEN-1:0] neg_lanes(input logic [XLEN-1:0] x, input logic [2:0] sew,
                                                 input logic [3:0] neg);
        neg_lanes = x;
        case (sew)
            SEW_8:
                for (int b = 0; b < 4; b++)
                    if (neg[b]) neg_lanes[8*b +: 8] = 8'h00 - x[8*b +: 8];
            SEW_16:
                for (int h = 0; h < 2; h++)
                    if (neg[h]) neg_lanes[16*h +: 16] = 16'h0000 - x[16*h +: 16];
            default:
                if (neg[0]) neg_lanes = 32'h0000_0000 - x;
        endcase
    endfunction

endpackage

// File: rtl/v_div_step.sv
// One restoring-division step on all lanes of a packed word.
// Borrows are killed at lane starts so lanes never interact.
module v_div_step
    import v_div_pkg::*;
(
    input  logic [2:0]      sew,
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] dsr,
    input  logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] dvd_nxt,
    output logic [XLEN-1:0] quo_nxt
);

    logic [3:0]      start, top, din, ok, lane_ok;
    logic [XLEN-1:0] sh, diff;
    logic            brw;
    logic [1:0]      ln;

    always_comb begin
        start   = lane_start(sew);
        top     = lane_top(sew);
        din     = lane_msb(dvd, sew);
        sh      = {rem[XLEN-2:0], 1'b0};
        diff    = '0;
        ok      = '0;
        lane_ok = '0;
        brw     = 1'b0;
        ln      = 2'd0;
        for (int b = 0; b < 4; b++) begin
            ln = lane_of_byte(sew, 2'(b));
            if (start[b]) begin
                sh[8*b] = din[ln];
                brw     = 1'b0;
            end
            {brw, diff[8*b +: 8]} = {1'b0, sh[8*b +: 8]} - {1'b0, dsr[8*b +: 8]} - {8'h00, brw};
            // Trial result is non-negative if a bit shifted out of the lane or no final borrow.
            ok[b] = rem[8*b+7] | ~brw;
            if (top[b]) lane_ok[ln] = ok[b];
        end

        rem_nxt = '0;
        dvd_nxt = {dvd[XLEN-2:0], 1'b0};
        quo_nxt = {quo[XLEN-2:0], 1'b0};
        for (int b = 0; b < 4; b++) begin
            ln = lane_of_byte(sew, 2'(b));
            rem_nxt[8*b +: 8] = lane_ok[ln] ? diff[8*b +: 8] : sh[8*b +: 8];
            if (start[b]) begin
                quo_nxt[8*b] = lane_ok[ln];
                dvd_nxt[8*b] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/v_div.sv
// Packed-SIMD integer divide/remainder: 4x8, 2x16 or 1x32 lanes, restoring,
// one quotient bit per lane per cycle, valid/ready on both sides.
module v_div
    import v_div_pkg::*;
(
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_A,
    input  logic [XLEN-1:0] op_B,
    input  logic [2:0]      sew,
    input  logic            is_div,
    input  logic            is_signed,
    input  logic            is_rem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    state_t          state;
    logic [XLEN-1:0] a_q, b_q, dvd, dsr, rem, quo;
    logic [2:0]      sew_q;
    logic            sgn_q, rem_q, div_q;
    logic [4:0]      cnt;
    logic [3:0]      neg_a, neg_b, dz, ov;

    logic [XLEN-1:0] rem_nxt, dvd_nxt, quo_nxt;
    logic [3:0]      p_sa, p_sb, p_dz, p_ov;
    logic [5:0]      p_n;
    logic [XLEN-1:0] fq, fr;
    logic [1:0]      fl;

    v_div_step u_step (
        .sew     (sew_q),
        .rem     (rem),
        .dvd     (dvd),
        .dsr     (dsr),
        .quo     (quo),
        .rem_nxt (rem_nxt),
        .dvd_nxt (dvd_nxt),
        .quo_nxt (quo_nxt)
    );

    always_comb begin
        p_sa = sgn_q ? lane_msb(a_q, sew_q) : 4'b0000;
        p_sb = sgn_q ? lane_msb(b_q, sew_q) : 4'b0000;
        p_dz = lane_zero(b_q, sew_q);
        // Most-negative dividend: only the lane MSB set. Divisor -1: all ones.
        p_ov = sgn_q ? (lane_msb(a_q, sew_q) & lane_zero(a_q & ~msb_mask(sew_q), sew_q)
                        & lane_zero(~b_q, sew_q)) : 4'b0000;
        p_n  = n_iter(sew_q) - 6'd1;
    end

    always_comb begin
        fq = neg_lanes(quo, sew_q, neg_a ^ neg_b);
        fr = neg_lanes(rem, sew_q, neg_a);
        fl = 2'd0;
        for (int b = 0; b < 4; b++) begin
            fl = lane_of_byte(sew_q, 2'(b));
            if (dz[fl]) begin
                fq[8*b +: 8] = 8'hFF;
                fr[8*b +: 8] = a_q[8*b +: 8];
            end else if (ov[fl]) begin
                fq[8*b +: 8] = a_q[8*b +: 8];
                fr[8*b +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sew_q     <= SEW_8;
            sgn_q     <= 1'b0;
            rem_q     <= 1'b0;
            div_q     <= 1'b0;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
            neg_a     <= '0;
            neg_b     <= '0;
            dz        <= '0;
            ov        <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= op_A;
                    b_q      <= op_B;
                    sew_q    <= sew;
                    sgn_q    <= is_signed;
                    rem_q    <= is_rem;
                    div_q    <= is_div;
                    in_ready <= 1'b0;
                    state    <= PREP;
                end
                PREP: if (!sew_legal(sew_q) || !div_q) begin
                    result    <= '0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end else begin
                    neg_a <= p_sa;
                    neg_b <= p_sb;
                    dz    <= p_dz;
                    ov    <= p_ov;
                    dvd   <= neg_lanes(a_q, sew_q, p_sa);
                    dsr   <= neg_lanes(b_q, sew_q, p_sb);
                    rem   <= '0;
                    quo   <= '0;
                    cnt   <= p_n[4:0];
                    state <= CALC;
                end
                CALC: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    quo <= quo_nxt;
                    if (cnt == 5'd0) state <= FIX;
                    else             cnt   <= cnt - 5'd1;
                end
                FIX: begin
                    result    <= rem_q ? fr : fq;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v_div.sv
// Scoreboard bench for v_div: directed ops push expected result and
// out_valid cycle; a negedge monitor checks latency and handshaken results.
module tb_v_div;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] op_A, op_B, result;
    logic [2:0]  sew;
    logic        is_div, is_signed, is_rem;

    typedef struct {
        logic [31:0] res;
        int          vcyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    v_div dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_A      (op_A),
        .op_B      (op_B),
        .sew       (sew),
        .is_div    (is_div),
        .is_signed (is_signed),
        .is_rem    (is_rem),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: latency on out_valid rise, value on handshake.
    always @(negedge clk) begin
        if (nrst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
                else chk({sb[0].name, "_latency"}, 32'(cyc), 32'(sb[0].vcyc));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                chk(sb[0].name, result, sb[0].res);
                void'(sb.pop_front());
            end
            prev_valid = out_valid;
        end
    end

    // Call at a negedge; accept happens on the following posedge.
    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] s, input logic sg, input logic rm, input logic dv,
                         input logic [31:0] exp, input int lat);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk({name, "_accept_timeout"}, 32'd0, 32'd1);
            return;
        end
        op_A = a; op_B = b; sew = s; is_signed = sg; is_rem = rm; is_div = dv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{exp, cyc + lat, name});
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble operands after accept; they must be ignored.
        op_A = $urandom; op_B = $urandom; sew = 3'($urandom_range(0, 7));
        is_signed = 1'($urandom); is_rem = 1'($urandom); is_div = 1'($urandom);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        nrst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_A = '0; op_B = '0; sew = 3'b000; is_div = 1'b1; is_signed = 1'b0; is_rem = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        nrst = 1'b0;
        @(negedge clk);

        issue("t1_q32s", 32'd100, 32'hFFFF_FFF9, 3'b010, 1, 0, 1, 32'hFFFF_FFF2, 34); drain(100);
        issue("t1_r32s", 32'd100, 32'hFFFF_FFF9, 3'b010, 1, 1, 1, 32'h0000_0002, 34); drain(100);
        issue("t2_q8s",  32'h800A_F964, 32'hFF00_0307, 3'b000, 1, 0, 1, 32'h80FF_FE0E, 10); drain(100);
        issue("t2_r8s",  32'h800A_F964, 32'hFF00_0307, 3'b000, 1, 1, 1, 32'h000A_FF02, 10); drain(100);
        issue("t3_q16u", 32'hFFFF_0064, 32'h0002_0007, 3'b001, 0, 0, 1, 32'h7FFF_000E, 18); drain(100);
        issue("t3_r16u", 32'hFFFF_0064, 32'h0002_0007, 3'b001, 0, 1, 1, 32'h0001_0002, 18); drain(100);
        issue("q8u",     32'hFF64_0A00, 32'h1007_0300, 3'b000, 0, 0, 1, 32'h0F0E_03FF, 10); drain(100);
        issue("r8u",     32'hFF64_0A00, 32'h1007_0300, 3'b000, 0, 1, 1, 32'h0F02_0100, 10); drain(100);
        issue("q16s",    32'hFF9C_8000, 32'h0007_FFFF, 3'b001, 1, 0, 1, 32'hFFF2_8000, 18); drain(100);
        issue("r16s",    32'hFF9C_8000, 32'h0007_FFFF, 3'b001, 1, 1, 1, 32'hFFFE_0000, 18); drain(100);
        issue("q32u_dz", 32'h1234_5678, 32'h0000_0000, 3'b010, 0, 0, 1, 32'hFFFF_FFFF, 34); drain(100);
        issue("r32u_dz", 32'h1234_5678, 32'h0000_0000, 3'b010, 0, 1, 1, 32'h1234_5678, 34); drain(100);

        // Backpressure: result held, second request ignored, accept right after release.
        out_ready = 1'b0;
        issue("bp_q8s", 32'h800A_F964, 32'hFF00_0307, 3'b000, 1, 0, 1, 32'h80FF_FE0E, 10);
        begin
            int t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            op_A = 32'd7; op_B = 32'd1; sew = 3'b010; is_div = 1'b1; in_valid = 1'b1;
            @(negedge clk);
            chk("bp_result_hold", result, 32'h80FF_FE0E);
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid), 32'd0);
        chk("bp_result_kept", result, 32'h80FF_FE0E);
        issue("bp_next_r16u", 32'hFFFF_0064, 32'h0002_0007, 3'b001, 0, 1, 1, 32'h0001_0002, 18);
        drain(100);

        // Reset at the 4th edge after accept aborts silently.
        op_A = 32'd100; op_B = 32'd7; sew = 3'b010; is_signed = 1'b0; is_rem = 1'b0; is_div = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", result, 32'h0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("rst_mid_no_output", 32'(out_valid), 32'd0);
        issue("post_rst_q32s", 32'd100, 32'hFFFF_FFF9, 3'b010, 1, 0, 1, 32'hFFFF_FFF2, 34); drain(100);

        // Illegal sew and non-divide ops: immediate zero result.
        issue("illegal_sew", 32'h1234_5678, 32'h0000_0003, 3'b011, 0, 0, 1, 32'h0, 1); drain(20);
        issue("r32u_refill", 32'h1234_5678, 32'h0000_0000, 3'b010, 0, 1, 1, 32'h1234_5678, 34); drain(100);
        issue("not_div",     32'h1234_5678, 32'h0000_0003, 3'b000, 0, 0, 0, 32'h0, 1); drain(20);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
